// File: rtl/ysyx_22040386_pipe_hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ysyx_22040386_pipe_hazard_ctrl : 5-stage pipeline stall/flush sequencer with
// memory-wait watchdog. Optional perf counters: YSYX_HAZARD_PERF_EN. Rev 1.0
// ---------------------------------------------------------------------------
module ysyx_22040386_pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_idex_memread,
  input  logic [4:0]  i_idex_rd,
  input  logic [4:0]  i_id_rs1,
  input  logic [4:0]  i_id_rs2,
  input  logic        i_id_rs1_used,
  input  logic        i_id_rs2_used,
  input  logic        i_ex_redirect,
  input  logic        i_mdu_busy,
  input  logic        i_exmem_mem_req,
  input  logic        i_dmem_ready,
  output logic        o_pc_hold,
  output logic        o_ifid_hold,
  output logic        o_ifid_flush,
  output logic        o_idex_hold,
  output logic        o_idex_bubble,
  output logic        o_exmem_hold,
  output logic        o_memwb_bubble,
  output logic        o_mem_timeout
`ifdef YSYX_HAZARD_PERF_EN
  ,
  output logic [31:0] o_perf_lu_cnt,
  output logic [31:0] o_perf_stall_cnt,
  output logic [31:0] o_perf_flush_cnt
`endif
);

  localparam logic [2:0] C_FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] C_WD_LAST    = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MDU_WAIT = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] flush_cnt_q, flush_cnt_d;
  logic [7:0] wd_cnt_q, wd_cnt_d;
  logic       timeout_q, timeout_d;

  logic w_lu;
  logic w_memw;
  logic w_in_flush;

  assign w_lu = i_idex_memread && (i_idex_rd != 5'd0) &&
                ((i_id_rs1_used && (i_idex_rd == i_id_rs1)) ||
                 (i_id_rs2_used && (i_idex_rd == i_id_rs2)));
  assign w_memw     = i_exmem_mem_req && !i_dmem_ready;
  assign w_in_flush = (state_q == FLUSH);

  always_comb begin
    state_d        = RUN;
    flush_cnt_d    = flush_cnt_q;
    o_pc_hold      = 1'b0;
    o_ifid_hold    = 1'b0;
    o_ifid_flush   = 1'b0;
    o_idex_hold    = 1'b0;
    o_idex_bubble  = 1'b0;
    o_exmem_hold   = 1'b0;
    o_memwb_bubble = 1'b0;

    if (w_memw) begin
      o_pc_hold      = 1'b1;
      o_ifid_hold    = 1'b1;
      o_idex_hold    = 1'b1;
      o_exmem_hold   = 1'b1;
      o_memwb_bubble = 1'b1;
      // A stall inside a flush window freezes the window rather than dropping it.
      if (w_in_flush) begin
        o_ifid_flush = 1'b1;
        state_d      = FLUSH;
      end else begin
        state_d      = MEM_WAIT;
      end
    end else if (i_mdu_busy) begin
      o_pc_hold   = 1'b1;
      o_ifid_hold = 1'b1;
      o_idex_hold = 1'b1;
      if (w_in_flush) begin
        o_ifid_flush = 1'b1;
        state_d      = FLUSH;
      end else begin
        state_d      = MDU_WAIT;
      end
    end else if (i_ex_redirect) begin
      o_ifid_flush  = 1'b1;
      o_idex_bubble = 1'b1;
      flush_cnt_d   = C_FLUSH_LOAD;
      state_d       = (C_FLUSH_LOAD != 3'd0) ? FLUSH : RUN;
    end else if (w_in_flush) begin
      o_ifid_flush = 1'b1;
      flush_cnt_d  = flush_cnt_q - 3'd1;
      state_d      = (flush_cnt_q <= 3'd1) ? RUN : FLUSH;
    end else if (w_lu) begin
      o_pc_hold     = 1'b1;
      o_ifid_hold   = 1'b1;
      o_idex_bubble = 1'b1;
    end

    if (o_ifid_flush) o_ifid_hold   = 1'b0;
    if (o_idex_hold)  o_idex_bubble = 1'b0;
  end

  // Watchdog saturates so a very long wait cannot wrap back under the limit.
  always_comb begin
    wd_cnt_d  = 8'd0;
    timeout_d = timeout_q;
    if (w_memw) begin
      wd_cnt_d = (wd_cnt_q == 8'hFF) ? wd_cnt_q : wd_cnt_q + 8'd1;
      if (wd_cnt_q >= C_WD_LAST) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      flush_cnt_q <= 3'd0;
      wd_cnt_q    <= 8'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign o_mem_timeout = timeout_q;

`ifdef YSYX_HAZARD_PERF_EN
  logic [31:0] perf_lu_q, perf_lu_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  // A load-use bubble is the only case with PC held and ID/EX bubbled.
  always_comb begin
    perf_lu_d    = perf_lu_q + {31'd0, (o_pc_hold && o_idex_bubble)};
    perf_stall_d = perf_stall_q + {31'd0, (w_memw || i_mdu_busy)};
    perf_flush_d = perf_flush_q + {31'd0, o_ifid_flush};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_lu_q    <= 32'd0;
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
    end else begin
      perf_lu_q    <= perf_lu_d;
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign o_perf_lu_cnt    = perf_lu_q;
  assign o_perf_stall_cnt = perf_stall_q;
  assign o_perf_flush_cnt = perf_flush_q;
`endif

endmodule
`default_nettype wire
